// File: rtl/fifo_occupancy_monitor.sv
`default_nettype none
// ============================================================================
// Module   : fifo_occupancy_monitor
// Purpose  : Passive occupancy, watermark, handshake statistics and near-full
//            alarm for a streaming FIFO, readable through a small register port.
// Revision : 1.0
// ============================================================================
module fifo_occupancy_monitor #(
    parameter int COUNT_W  = 14,
    parameter int ALARM_HI = 12288,
    parameter int ALARM_LO = 8192,
    parameter int STAT_W   = 32
) (
    input  logic               ap_clk,
    input  logic               ap_rst,
    input  logic [COUNT_W-1:0] count,
    input  logic               in_tvalid,
    input  logic               in_tready,
    input  logic               out_tvalid,
    input  logic               out_tready,
    input  logic               clear,
    input  logic               rd_en,
    input  logic [2:0]         rd_addr,
    output logic [STAT_W-1:0]  rd_data,
    output logic               rd_valid,
    output logic               alarm
);

    localparam logic [COUNT_W-1:0] c_alarm_hi = COUNT_W'(ALARM_HI);
    localparam logic [COUNT_W-1:0] c_alarm_lo = COUNT_W'(ALARM_LO);
    localparam logic [STAT_W-1:0]  c_stat_max = {STAT_W{1'b1}};
    localparam logic [STAT_W-1:0]  c_stat_one = STAT_W'(1);
    localparam logic [31:0]        c_id       = 32'h464D_0001;
    localparam logic [0:0]         c_st_idle  = 1'b0;
    localparam logic [0:0]         c_st_alarm = 1'b1;

    logic [COUNT_W-1:0] r_count_s;
    logic               r_in_valid_s;
    logic               r_in_ready_s;
    logic               r_out_valid_s;
    logic               r_out_ready_s;
    logic               r_clear_s;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_count_s     <= '0;
            r_in_valid_s  <= 1'b0;
            r_in_ready_s  <= 1'b0;
            r_out_valid_s <= 1'b0;
            r_out_ready_s <= 1'b0;
            r_clear_s     <= 1'b0;
        end else begin
            r_count_s     <= count;
            r_in_valid_s  <= in_tvalid;
            r_in_ready_s  <= in_tready;
            r_out_valid_s <= out_tvalid;
            r_out_ready_s <= out_tready;
            r_clear_s     <= clear;
        end
    end

    // Event index order matches register addresses 2..5.
    logic [3:0] w_event;
    assign w_event = {r_out_valid_s &  r_out_ready_s,
                      r_in_valid_s  &  r_in_ready_s,
                      r_out_ready_s & ~r_out_valid_s,
                      r_in_valid_s  & ~r_in_ready_s};

    logic [STAT_W-1:0]  r_stat [4];
    logic [COUNT_W-1:0] r_watermark;
    logic               r_overflow;
    logic [3:0]         w_reach_max;

    always_comb begin
        w_reach_max = '0;
        for (int i = 0; i < 4; i++) begin
            w_reach_max[i] = w_event[i] && (r_stat[i] == (c_stat_max - c_stat_one));
        end
    end

    // The sampled clear takes priority over the sample taken in the same cycle.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            for (int i = 0; i < 4; i++) r_stat[i] <= '0;
            r_watermark <= '0;
            r_overflow  <= 1'b0;
        end else if (r_clear_s) begin
            for (int i = 0; i < 4; i++) r_stat[i] <= '0;
            r_watermark <= '0;
            r_overflow  <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_event[i] && (r_stat[i] != c_stat_max)) begin
                    r_stat[i] <= r_stat[i] + c_stat_one;
                end
            end
            if (r_count_s > r_watermark) r_watermark <= r_count_s;
            if (|w_reach_max) r_overflow <= 1'b1;
        end
    end

    logic [0:0] r_state;
    logic [0:0] w_state_next;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) r_state <= c_st_idle;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:  if (r_count_s >= c_alarm_hi) w_state_next = c_st_alarm;
            c_st_alarm: if (r_count_s <= c_alarm_lo) w_state_next = c_st_idle;
            default:    w_state_next = c_st_idle;
        endcase
    end

    assign alarm = (r_state == c_st_alarm);

    logic [STAT_W-1:0] w_rd_mux;

    always_comb begin
        w_rd_mux = '0;
        case (rd_addr)
            3'd0: w_rd_mux = STAT_W'(r_count_s);
            3'd1: w_rd_mux = STAT_W'(r_watermark);
            3'd2: w_rd_mux = r_stat[0];
            3'd3: w_rd_mux = r_stat[1];
            3'd4: w_rd_mux = r_stat[2];
            3'd5: w_rd_mux = r_stat[3];
            3'd6: w_rd_mux = STAT_W'({r_overflow, alarm});
            3'd7: w_rd_mux = STAT_W'(c_id);
            default: w_rd_mux = '0;
        endcase
    end

    // Read strobe is captured straight into the output register.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= w_rd_mux;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_occupancy_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_occupancy_monitor
// Purpose  : Table-driven, directed and randomized checks of the monitor
//            against a history-based reference model.
// Revision : 1.0
// ============================================================================
module tb_fifo_occupancy_monitor;

    localparam int HI = 12288;
    localparam int LO = 8192;
    localparam int HN = 4096;
    localparam logic [31:0] ID = 32'h464D_0001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] count = '0;
    logic        in_tvalid = 0, in_tready = 0, out_tvalid = 0, out_tready = 0;
    logic        clear = 0, rd_en = 0;
    logic [2:0]  rd_addr = '0;
    logic [31:0] rd_data32;
    logic        rd_valid32, alarm32;
    logic [7:0]  rd_data8;
    logic        rd_valid8, alarm8;

    always #5 clk = ~clk;

    fifo_occupancy_monitor #(.COUNT_W(14), .ALARM_HI(HI), .ALARM_LO(LO), .STAT_W(32)) dut32 (
        .ap_clk(clk), .ap_rst(rst), .count(count),
        .in_tvalid(in_tvalid), .in_tready(in_tready),
        .out_tvalid(out_tvalid), .out_tready(out_tready),
        .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data32), .rd_valid(rd_valid32), .alarm(alarm32));

    fifo_occupancy_monitor #(.COUNT_W(14), .ALARM_HI(HI), .ALARM_LO(LO), .STAT_W(8)) dut8 (
        .ap_clk(clk), .ap_rst(rst), .count(count),
        .in_tvalid(in_tvalid), .in_tready(in_tready),
        .out_tvalid(out_tvalid), .out_tready(out_tready),
        .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data8), .rd_valid(rd_valid8), .alarm(alarm8));

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [31:0] last32 = '0;
    logic [31:0] last8  = '0;

    // Everything driven since reset release, indexed by cycle.
    bit [13:0] h_cnt [HN];
    bit        h_iv [HN], h_ir [HN], h_ov [HN], h_or [HN], h_clr [HN], h_rd [HN];
    bit [2:0]  h_addr [HN];

    typedef struct {
        string       nm;
        int          cnt;
        bit          iv, ir, ov, orr, clr, rd;
        int          addr;
        int          reps;
        int          chk;   // 0 none, 1 check 32-bit read, 2 check 8-bit read
        logic [31:0] exp;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(string nm, int cnt, bit iv, bit ir, bit ov, bit orr, bit clr,
                                bit rd, int addr, int reps, int chk, logic [31:0] exp);
        vec_t v;
        v.nm = nm; v.cnt = cnt; v.iv = iv; v.ir = ir; v.ov = ov; v.orr = orr; v.clr = clr;
        v.rd = rd; v.addr = addr; v.reps = reps; v.chk = chk; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Hysteresis evaluated over every count sampled up to cycle 'upto'.
    function automatic logic m_alarm(int upto);
        logic a;
        a = 1'b0;
        for (int i = 0; i <= upto; i++) begin
            if (h_cnt[i] >= HI)      a = 1'b1;
            else if (h_cnt[i] <= LO) a = 1'b0;
        end
        return a;
    endfunction

    // Expected read data for a read driven in cycle j on a sw-bit instance:
    // statistics cover the cycles after the last clear, up to cycle j-2.
    function automatic logic [31:0] m_read(int j, logic [2:0] a, int sw);
        int    w, lc, wm, k;
        int    n [4];
        longint mx;
        logic  ovf;
        logic [31:0] r;
        w  = j - 2;
        lc = -1;
        wm = 0;
        mx = (longint'(1) << sw) - 1;
        for (int i = 0; i < 4; i++) n[i] = 0;
        for (int i = 0; i <= w; i++) if (h_clr[i]) lc = i;
        for (int i = lc + 1; i <= w; i++) begin
            if (int'(h_cnt[i]) > wm) wm = int'(h_cnt[i]);
            if (h_iv[i] && !h_ir[i]) n[0]++;
            if (h_or[i] && !h_ov[i]) n[1]++;
            if (h_iv[i] &&  h_ir[i]) n[2]++;
            if (h_ov[i] &&  h_or[i]) n[3]++;
        end
        ovf = 1'b0;
        for (int i = 0; i < 4; i++) if (n[i] >= mx) ovf = 1'b1;
        r = '0;
        case (a)
            3'd0: r = (j >= 1) ? 32'(h_cnt[j-1]) : 32'd0;
            3'd1: r = 32'(wm);
            3'd6: r = {30'd0, ovf, m_alarm(w)};
            3'd7: r = ID;
            default: begin
                k = int'(a) - 2;
                r = (n[k] >= mx) ? 32'(mx) : 32'(n[k]);
            end
        endcase
        return 32'(longint'(r) & mx);
    endfunction

    // Log this cycle's drive, clock, then compare every output with the model.
    task automatic step();
        logic [31:0] e32, e8;
        h_cnt[cyc] = count;  h_iv[cyc] = in_tvalid; h_ir[cyc] = in_tready;
        h_ov[cyc] = out_tvalid; h_or[cyc] = out_tready; h_clr[cyc] = clear;
        h_rd[cyc] = rd_en;   h_addr[cyc] = rd_addr;
        @(posedge clk);
        #1;
        chk("rd_valid32", 32'(rd_valid32), 32'(h_rd[cyc]));
        chk("rd_valid8", 32'(rd_valid8), 32'(h_rd[cyc]));
        if (h_rd[cyc]) begin
            e32 = m_read(cyc, h_addr[cyc], 32);
            e8  = m_read(cyc, h_addr[cyc], 8);
            last32 = e32;
            last8  = e8;
        end
        chk("rd_data32", rd_data32, last32);
        chk("rd_data8", 32'(rd_data8), last8);
        chk("alarm32", 32'(alarm32), 32'(m_alarm(cyc - 1)));
        chk("alarm8", 32'(alarm8), 32'(m_alarm(cyc - 1)));
        cyc++;
    endtask

    task automatic drive(input int cnt, input bit iv, input bit ir, input bit ov, input bit orr,
                         input bit clr, input bit rd, input int addr);
        count = 14'(cnt); in_tvalid = iv; in_tready = ir; out_tvalid = ov; out_tready = orr;
        clear = clr; rd_en = rd; rd_addr = 3'(addr);
    endtask

    task automatic run_table();
        foreach (tv[t]) begin
            drive(tv[t].cnt, tv[t].iv, tv[t].ir, tv[t].ov, tv[t].orr, tv[t].clr, tv[t].rd, tv[t].addr);
            for (int r = 0; r < tv[t].reps; r++) step();
            if (tv[t].chk == 1)      chk(tv[t].nm, rd_data32, tv[t].exp);
            else if (tv[t].chk == 2) chk(tv[t].nm, 32'(rd_data8), tv[t].exp);
        end
        tv.delete();
    endtask

    task automatic rand_cycles(input int n);
        int c;
        c = int'(count);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) c = int'($urandom_range(0, 16383));
            drive(c, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 59) == 0), ($urandom_range(0, 9) < 7), int'($urandom_range(0, 7)));
            step();
        end
    endtask

    task automatic release_reset();
        for (int i = 0; i < HN; i++) begin
            h_cnt[i] = '0; h_iv[i] = 0; h_ir[i] = 0; h_ov[i] = 0; h_or[i] = 0;
            h_clr[i] = 0; h_rd[i] = 0; h_addr[i] = '0;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        last32 = '0;
        last8 = '0;
    endtask

    initial begin
        release_reset();

        for (int a = 0; a < 8; a++)
            tv.push_back(mk("reset_read", 0, 0, 0, 0, 0, 0, 1, a, 1, 1, (a == 7) ? ID : 32'd0));
        tv.push_back(mk("reset_id8", 0, 0, 0, 0, 0, 0, 1, 7, 1, 2, 32'h01));
        tv.push_back(mk("cnt0", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk("cnt100", 100, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk("cnt40", 40, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0));
        tv.push_back(mk("watermark", 40, 0, 0, 0, 0, 0, 1, 1, 1, 1, 100));
        tv.push_back(mk("live_count", 40, 0, 0, 0, 0, 0, 1, 0, 1, 1, 40));
        tv.push_back(mk("stall_drv", 40, 1, 0, 0, 0, 0, 0, 0, 10, 0, 0));
        tv.push_back(mk("beat_drv", 40, 1, 1, 0, 0, 0, 0, 0, 5, 0, 0));
        tv.push_back(mk("idle", 40, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0));
        tv.push_back(mk("stall_cnt", 40, 0, 0, 0, 0, 0, 1, 2, 1, 1, 10));
        tv.push_back(mk("in_beats", 40, 0, 0, 0, 0, 0, 1, 4, 1, 1, 5));
        run_table();

        drive(12287, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();
        chk("alarm_below_hi", 32'(alarm32), 0);
        count = 14'd12288;
        step();
        chk("alarm_hi_plus1", 32'(alarm32), 0);
        step();
        chk("alarm_hi_plus2", 32'(alarm32), 1);
        count = 14'd9000;
        repeat (3) step();
        chk("alarm_hold_mid", 32'(alarm32), 1);
        count = 14'd8192;
        step();
        chk("alarm_lo_plus1", 32'(alarm32), 1);
        step();
        chk("alarm_lo_plus2", 32'(alarm32), 0);

        tv.push_back(mk("hi_count", 13000, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0));
        tv.push_back(mk("pre_clear", 13000, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
        tv.push_back(mk("idle", 13000, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0));
        tv.push_back(mk("starve_drv", 13000, 0, 0, 0, 1, 0, 0, 0, 300, 0, 0));
        tv.push_back(mk("idle", 13000, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0));
        tv.push_back(mk("starve_sat8", 13000, 0, 0, 0, 0, 0, 1, 3, 1, 2, 255));
        tv.push_back(mk("status_ovf8", 13000, 0, 0, 0, 0, 0, 1, 6, 1, 2, 3));
        tv.push_back(mk("starve_32", 13000, 0, 0, 0, 0, 0, 1, 3, 1, 1, 300));
        tv.push_back(mk("clear", 13000, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
        tv.push_back(mk("idle", 13000, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0));
        tv.push_back(mk("starve_cleared8", 13000, 0, 0, 0, 0, 0, 1, 3, 1, 2, 0));
        tv.push_back(mk("status_cleared8", 13000, 0, 0, 0, 0, 0, 1, 6, 1, 2, 1));
        run_table();
        chk("alarm_kept_on_clear", 32'(alarm32), 1);

        tv.push_back(mk("clear", 100, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
        tv.push_back(mk("idle", 100, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0));
        tv.push_back(mk("beats7", 100, 1, 1, 0, 0, 0, 0, 0, 7, 0, 0));
        tv.push_back(mk("idle", 100, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0));
        tv.push_back(mk("read_on_clear", 100, 1, 1, 0, 0, 1, 1, 4, 1, 1, 7));
        tv.push_back(mk("idle", 100, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0));
        tv.push_back(mk("after_clear", 100, 0, 0, 0, 0, 0, 1, 4, 1, 1, 0));
        run_table();

        rand_cycles(600);

        // Force the alarm on, then reset mid-cycle and expect outputs to drop at once.
        drive(16000, 1, 1, 1, 1, 0, 1, 7);
        repeat (3) step();
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_rd_data32", rd_data32, 0);
        chk("async_rst_rd_valid32", 32'(rd_valid32), 0);
        chk("async_rst_alarm32", 32'(alarm32), 0);
        chk("async_rst_rd_data8", 32'(rd_data8), 0);
        release_reset();
        rand_cycles(300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_occupancy_monitor.md
# fifo_occupancy_monitor

- Passive observer that sits beside a StreamingFIFO instance and reads that FIFO's occupancy `count` output and its two AXI-Stream handshakes.
- Records:
  - live occupancy and high-watermark;
  - producer back-pressure cycles and consumer starvation cycles;
  - beat totals on each side.
- Raises a hysteretic near-full alarm.
- Exposes all statistics through a one-cycle-latency register read port, so the FIFO depth chosen at build time can be checked against real traffic.

## Interface

Parameters:
- `COUNT_W`, 14: width of the monitored FIFO's `count` output.
- `ALARM_HI`, 12288: alarm sets when sampled count >= this value.
- `ALARM_LO`, 8192: alarm clears when sampled count <= this value. Must be < `ALARM_HI`.
- `STAT_W`, 32: width of the event counters.

Ports:
- `ap_clk`  in  1  single clock; all logic is on the rising edge.
- `ap_rst`  in  1  asynchronous reset, active-high.
- `count`  in  COUNT_W  occupancy reported by the monitored FIFO.
- `in_tvalid`, `in_tready`  in  1 each  taps of the FIFO's input handshake.
- `out_tvalid`, `out_tready`  in  1 each  taps of the FIFO's output handshake.
- `clear`  in  1  synchronous clear of the statistics registers.
- `rd_en`  in  1  register read strobe.
- `rd_addr`  in  3  register select.
- `rd_data`  out  STAT_W  read data.
- `rd_valid`  out  1  read data qualifier.
- `alarm`  out  1  near-full alarm.

## Operation

- The block never drives any stream signal. All inputs are registered once (sample stage) before use.
- Register map (`rd_addr`):
  - 0: current count (zero-extended).
  - 1: high-watermark.
  - 2: stall cycles, counting `in_tvalid & !in_tready`.
  - 3: starve cycles, counting `out_tready & !out_tvalid`.
  - 4: input beats, counting `in_tvalid & in_tready`.
  - 5: output beats, counting `out_tvalid & out_tready`.
  - 6: status, with bit0 = `alarm` and bit1 = sticky overflow (any counter has saturated).
  - 7: constant 0x464D0001 (ID/version).
- Counter rules:
  - Counters 2-5 are `STAT_W`-bit unsigned and saturate at all-ones; they do not wrap.
  - The first saturation of any counter sets the sticky overflow bit.
- High-watermark: replaced by the sampled count whenever the sampled count is strictly greater than the current watermark.
- Alarm state machine:
  - States are IDLE and ALARM.
  - IDLE goes to ALARM when sampled count >= `ALARM_HI`.
  - ALARM goes to IDLE when sampled count <= `ALARM_LO`.
  - Counts between the two thresholds hold the current state.
  - `alarm` is 1 exactly in ALARM.
- `clear`:
  - Zeroes the watermark, counters 2-5 and sticky overflow in the following cycle.
  - Does not affect the alarm state or the sample stage.
  - If `clear` coincides with an event, the clear wins: the register is 0 afterwards, and that event is not counted.
- A read in the same cycle as `clear` returns the pre-clear value.
- Reset:
  - All statistics, the sample stage, `rd_data` and `rd_valid` go to 0; the alarm state goes to IDLE.
  - Reset asserted mid-operation discards everything immediately (asynchronous). The first sample is taken on the first edge after release.

## Timing

- Event-to-register latency: an input event at edge N is sampled at N+1 and reflected in the statistics register at N+2.
- Read:
  - `rd_en` with `rd_addr` at edge N gives `rd_data` and `rd_valid=1` after edge N+1, for one cycle.
  - `rd_data` holds its last value while `rd_valid=0`.
  - Back-to-back reads are legal every cycle.
- Alarm: a count crossing sampled at edge N+1 changes `alarm` after edge N+2.
- There is no combinational path from any input to any output.

## Test plan

- Reset, then read every address:
  - addresses 0-6 read 0;
  - address 7 reads 0x464D0001;
  - `rd_valid` is high one cycle after each `rd_en`.
- Drive count 0→100→40, then read addr 1 → 100. Read addr 0 while count is held at 40 → 40.
- 10 cycles of `in_tvalid=1, in_tready=0`, then 5 cycles with both high:
  - addr 2 → 10;
  - addr 4 → 5.
- Hysteresis: count 12287, then 12288, then 9000, then 8192:
  - `alarm` goes 0, then 1 two cycles after the 12288 sample;
  - stays 1 at 9000;
  - goes to 0 after 8192.
- With `STAT_W=8`, 300 starve cycles → addr 3 = 255 and addr 6 bit1 = 1. Assert `clear` → both read 0 and `alarm` is unchanged.
- Assert `clear` and `rd_en` (addr 4) in the same cycle as an input beat, with 7 beats already counted:
  - `rd_data` = 7;
  - a subsequent read of addr 4 = 0.
